// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
//
// Issue stage between instruction decode and the ALU. Each accepted
// instruction is decoded into an ALU operation code plus control flags, and
// is captured with its operands in a single EX register stage. The ALU
// operands are then built combinationally from that register. Register
// operands are bypassed from the MEM and WB stages. The MEM stage holds the
// younger result, so it wins over WB when both match.
//
// Ports
//   clk, reset        clock (rising edge) and asynchronous active-low reset
//   id_valid/id_ready decode handshake; id_ready is simply ~stall
//   opcode, funct3, funct7, rs1, rs2, rd
//                     decoded instruction fields
//   rs1_data, rs2_data, imm, pc
//                     register reads, sign-extended immediate, instruction PC
//   stall, flush      hold / kill the EX register (flush has priority)
//   mem_*/wb_*        forwarding sources from later pipeline stages
//   SrcA, SrcB, Operation, Jalr
//                     ALU operands and control
//   br_invert, is_branch, ex_valid, ex_rd, ex_regwrite, illegal
//                     flags that travel with the instruction in EX
// ---------------------------------------------------------------------------
module alu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  output logic [3:0]  Operation,
  output logic        Jalr,
  output logic        br_invert,
  output logic        is_branch,
  output logic        ex_valid,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        illegal
);

  // ALU operation codes understood by the downstream ALU
  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_XOR = 4'b0100,
    OP_SLT = 4'b0101,
    OP_LUI = 4'b0110,
    OP_SRL = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_SLL = 4'b1001,
    OP_SRA = 4'b1010,
    OP_BLT = 4'b1100,
    OP_BGE = 4'b1111
  } alu_op_e;

  // Where the A operand comes from
  typedef enum logic {
    SRCA_REG = 1'b0,
    SRCA_PC  = 1'b1
  } srca_sel_e;

  // Where the B operand comes from
  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } srcb_sel_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  alu_op_e   dec_op;
  srca_sel_e dec_a_sel;
  srcb_sel_e dec_b_sel;
  logic      dec_writes;
  logic      dec_regwrite;
  logic      dec_branch;
  logic      dec_invert;
  logic      dec_jalr;
  logic      dec_illegal;

  alu_op_e     ex_op;
  srca_sel_e   ex_a_sel;
  srcb_sel_e   ex_b_sel;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [31:0] ex_pc;

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  // Decode stalls upstream whenever EX is held
  assign id_ready = ~stall;

  // Instruction decode. The register-register and register-immediate ALU
  // groups share one funct3 map. The only differences are that the
  // immediate form always adds for funct3 000 and takes its B operand from
  // imm. Any encoding that is not recognised falls through to the illegal
  // flag. The override at the end then makes illegal instructions inert:
  // AND code, no write-back, no branch, no jump.
  always_comb begin
    dec_op      = OP_AND;
    dec_a_sel   = SRCA_REG;
    dec_b_sel   = SRCB_REG;
    dec_writes  = 1'b0;
    dec_branch  = 1'b0;
    dec_invert  = 1'b0;
    dec_jalr    = 1'b0;
    dec_illegal = 1'b0;

    case (opcode)
      OPC_R, OPC_I: begin
        dec_writes = 1'b1;
        dec_b_sel  = (opcode == OPC_I) ? SRCB_IMM : SRCB_REG;
        case (funct3)
          3'b000: begin
            if (opcode == OPC_I || funct7 == F7_BASE)
              dec_op = OP_ADD;
            else if (funct7 == F7_ALT)
              dec_op = OP_SUB;
            else
              dec_illegal = 1'b1;
          end
          3'b111: dec_op = OP_AND;
          3'b110: dec_op = OP_OR;
          3'b100: dec_op = OP_XOR;
          3'b010: dec_op = OP_SLT;
          3'b001: begin
            if (funct7 == F7_BASE)
              dec_op = OP_SLL;
            else
              dec_illegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE)
              dec_op = OP_SRL;
            else if (funct7 == F7_ALT)
              dec_op = OP_SRA;
            else
              dec_illegal = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end

      OPC_LOAD: begin
        dec_op     = OP_ADD;
        dec_b_sel  = SRCB_IMM;
        dec_writes = 1'b1;
      end

      OPC_STORE: begin
        dec_op    = OP_ADD;
        dec_b_sel = SRCB_IMM;
      end

      OPC_BRANCH: begin
        dec_branch = 1'b1;
        dec_b_sel  = SRCB_REG;
        case (funct3)
          3'b000: dec_op = OP_BEQ;
          3'b001: begin
            dec_op     = OP_BEQ;
            dec_invert = 1'b1;
          end
          3'b100: dec_op = OP_BLT;
          3'b101: dec_op = OP_BGE;
          default: dec_illegal = 1'b1;
        endcase
      end

      OPC_LUI: begin
        dec_op     = OP_LUI;
        dec_b_sel  = SRCB_IMM;
        dec_writes = 1'b1;
      end

      OPC_JAL: begin
        dec_op     = OP_ADD;
        dec_a_sel  = SRCA_PC;
        dec_b_sel  = SRCB_FOUR;
        dec_writes = 1'b1;
      end

      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          dec_op     = OP_ADD;
          dec_b_sel  = SRCB_IMM;
          dec_jalr   = 1'b1;
          dec_writes = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end

      default: dec_illegal = 1'b1;
    endcase

    if (dec_illegal) begin
      dec_op     = OP_AND;
      dec_writes = 1'b0;
      dec_branch = 1'b0;
      dec_invert = 1'b0;
      dec_jalr   = 1'b0;
    end
  end

  // Writes to x0 are dropped here so that later stages never see them
  assign dec_regwrite = dec_writes & (rd != 5'd0) & ~dec_illegal;

  // EX register. Reset and flush both return the stage to an empty, inert
  // state. A flush also clears the data fields, so a killed instruction can
  // never leak an operand. A stall freezes every bit. Otherwise a new
  // instruction is loaded on every edge. The side-effect flags are
  // qualified with id_valid, so a bubble can never look like a write,
  // branch, jump or trap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid    <= 1'b0;
      ex_op       <= OP_AND;
      ex_a_sel    <= SRCA_REG;
      ex_b_sel    <= SRCB_REG;
      Jalr        <= 1'b0;
      br_invert   <= 1'b0;
      is_branch   <= 1'b0;
      illegal     <= 1'b0;
      ex_rd       <= 5'd0;
      ex_regwrite <= 1'b0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rs1_data <= 32'd0;
      ex_rs2_data <= 32'd0;
      ex_imm      <= 32'd0;
      ex_pc       <= 32'd0;
    end else if (flush) begin
      ex_valid    <= 1'b0;
      ex_op       <= OP_AND;
      ex_a_sel    <= SRCA_REG;
      ex_b_sel    <= SRCB_REG;
      Jalr        <= 1'b0;
      br_invert   <= 1'b0;
      is_branch   <= 1'b0;
      illegal     <= 1'b0;
      ex_rd       <= 5'd0;
      ex_regwrite <= 1'b0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rs1_data <= 32'd0;
      ex_rs2_data <= 32'd0;
      ex_imm      <= 32'd0;
      ex_pc       <= 32'd0;
    end else if (!stall) begin
      ex_valid    <= id_valid;
      ex_op       <= dec_op;
      ex_a_sel    <= dec_a_sel;
      ex_b_sel    <= dec_b_sel;
      Jalr        <= id_valid & dec_jalr;
      br_invert   <= dec_invert;
      is_branch   <= id_valid & dec_branch;
      illegal     <= id_valid & dec_illegal;
      ex_rd       <= rd;
      ex_regwrite <= id_valid & dec_regwrite;
      ex_rs1      <= rs1;
      ex_rs2      <= rs2;
      ex_rs1_data <= rs1_data;
      ex_rs2_data <= rs2_data;
      ex_imm      <= imm;
      ex_pc       <= pc;
    end
  end

  // Operand bypass. The MEM result is younger than the WB result, so it is
  // checked first. Register x0 is hard-wired and is never bypassed, whatever
  // a later stage claims to be writing.
  always_comb begin
    fwd_a = ex_rs1_data;
    if (ex_rs1 != 5'd0 && mem_regwrite && mem_rd == ex_rs1)
      fwd_a = mem_result;
    else if (ex_rs1 != 5'd0 && wb_regwrite && wb_rd == ex_rs1)
      fwd_a = wb_result;

    fwd_b = ex_rs2_data;
    if (ex_rs2 != 5'd0 && mem_regwrite && mem_rd == ex_rs2)
      fwd_b = mem_result;
    else if (ex_rs2 != 5'd0 && wb_regwrite && wb_rd == ex_rs2)
      fwd_b = wb_result;
  end

  // Final operand selection. Only register operands pass through the
  // bypass network. pc, imm and the constant 4 are taken as captured.
  always_comb begin
    SrcA = (ex_a_sel == SRCA_PC) ? ex_pc : fwd_a;
    case (ex_b_sel)
      SRCB_IMM:  SrcB = ex_imm;
      SRCB_FOUR: SrcB = 32'd4;
      default:   SrcB = fwd_b;
    endcase
  end

  assign Operation = ex_op;

endmodule
